// File: rtl/mem_bus_if_pkg.sv
// mem_bus_if_pkg: shared types and constants for the memory bus interface unit
package mem_bus_if_pkg;
  typedef enum logic [1:0] {MEM_BYTE = 2'd0, MEM_HALF = 2'd1, MEM_WORD = 2'd2} mem_size_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} memif_state_t;
  localparam logic [31:0] MEM_ERR_DATA = 32'hDEADBEEF;
  function automatic logic misaligned(input mem_size_t size, input logic [1:0] lane);
    return (size == MEM_HALF && lane[0]) || (size == MEM_WORD && lane != 2'b00);
  endfunction
endpackage

// File: rtl/mem_bus_if_lane_align.sv
// mem_lane_align: combinational byte-lane steering for loads and stores
//   size, zext, lane    access width, zero-extend select, byte offset within word
//   wdata, bus_rdata    right-justified store data, raw read word
//   load_data           extracted and extended load value
//   wstrb, wdata_rep    store byte strobes, lane-replicated store data
module mem_lane_align
  import mem_bus_if_pkg::*;
(
  input  mem_size_t   size,
  input  logic        zext,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [31:0] load_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = bus_rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_data = size == MEM_BYTE ? {{24{~zext & b[7]}}, b} :
                size == MEM_HALF ? {{16{~zext & h[15]}}, h} : bus_rdata;
    wstrb = size == MEM_BYTE ? 4'b0001 << lane :
            size == MEM_HALF ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
    wdata_rep = size == MEM_BYTE ? {4{wdata[7:0]}} :
                size == MEM_HALF ? {2{wdata[15:0]}} : wdata;
  end
endmodule

// File: rtl/mem_bus_if.sv
// mem_bus_if: runs one MAR/MDR memory bus read or write per mem_start, returning load data to the MDR
//   clk, rst_n                         clock, synchronous active-low reset
//   mem_start/we/size/unsigned         transaction request from the control FSM
//   addr, wdata                        byte address and right-justified store data
//   rdata, mdr_valid                   registered load data, one-cycle completion pulse
//   mem_misalign, mem_err, busy        completion qualifiers, unit busy
//   bus_req/we/addr/wstrb/wdata        external bus request, held until bus_gnt
//   bus_gnt, bus_rvalid, bus_rdata     external bus grant and response
// Build option: define MEM_TIMEOUT_EN to abort RESP after TIMEOUT_CYCLES with mem_err.
module mem_bus_if
  import mem_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_start,
  input  logic        mem_we,
  input  mem_size_t   mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mdr_valid,
  output logic        mem_misalign,
  output logic        mem_err,
  output logic        busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  memif_state_t state, state_n;
  logic        we_q, uns_q, misalign_q, load_cap, tmo;
  mem_size_t   size_q;
  logic [31:0] addr_q, wdata_q, load_data;
  logic [3:0]  strb;
  mem_lane_align u_align (
    .size(size_q),
    .zext(uns_q),
    .lane(addr_q[1:0]),
    .wdata(wdata_q),
    .bus_rdata(bus_rdata),
    .load_data(load_data),
    .wstrb(strb),
    .wdata_rep(bus_wdata)
  );
  always_ff @(posedge clk)
    state <= !rst_n ? S_IDLE : state_n;
  // A misaligned access still passes through REQ, but with bus_req suppressed.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = mem_start ? S_REQ : S_IDLE;
      S_REQ:  state_n = misalign_q ? S_DONE : !bus_gnt ? S_REQ : bus_rvalid ? S_DONE : S_RESP;
      S_RESP: state_n = bus_rvalid || tmo ? S_DONE : S_RESP;
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    busy = state != S_IDLE;
    mdr_valid = state == S_DONE;
    bus_req = state == S_REQ && !misalign_q;
    load_cap = !we_q && ((bus_req && bus_gnt && bus_rvalid) || (state == S_RESP && bus_rvalid));
    mem_misalign = mdr_valid && misalign_q;
  end
  assign bus_we = we_q;
  assign bus_addr = {addr_q[31:2], 2'b00};
  assign bus_wstrb = we_q ? strb : 4'b0000;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 255 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
  logic          err_q;
  // The counter sits at zero outside RESP, so it is already clear on entry.
  assign tmo = state == S_RESP && !bus_rvalid && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign mem_err = mdr_valid && err_q;
`else
  assign tmo = 1'b0 && TIMEOUT_CYCLES > 0;
  assign mem_err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      we_q <= 1'b0;
      size_q <= MEM_BYTE;
      uns_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      misalign_q <= 1'b0;
      rdata <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && mem_start) begin
        we_q <= mem_we;
        size_q <= mem_size;
        uns_q <= mem_unsigned;
        addr_q <= addr;
        wdata_q <= wdata;
        misalign_q <= misaligned(mem_size, addr[1:0]);
      end
      if (load_cap) rdata <= load_data;
`ifdef MEM_TIMEOUT_EN
      if (tmo && !we_q) rdata <= MEM_ERR_DATA;
      cnt <= state == S_RESP ? cnt + 1'b1 : '0;
      err_q <= state == S_IDLE && mem_start ? 1'b0 : tmo ? 1'b1 : err_q;
`endif
    end
endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: directed self-checking bench for mem_bus_if
module tb_mem_bus_if;
  import mem_bus_if_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        mem_start = 1'b0, mem_we = 1'b0, mem_unsigned = 1'b0;
  mem_size_t   mem_size = MEM_WORD;
  logic [31:0] addr = '0, wdata = '0, rdata, bus_addr, bus_wdata, bus_rdata = '0;
  logic        mdr_valid, mem_misalign, mem_err, busy, bus_req, bus_we;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  int checks = 0, failures = 0;
  int r_lat;
  logic r_seen, r_unstable, r_we, r_mis, r_err;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_strb;
  mem_bus_if dut (
    .clk(clk), .rst_n(rst_n), .mem_start(mem_start), .mem_we(mem_we), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata), .rdata(rdata), .mdr_valid(mdr_valid),
    .mem_misalign(mem_misalign), .mem_err(mem_err), .busy(busy), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Starts a transaction in cycle 0; bus_gnt in cycle 1+gd, bus_rvalid in cycle 1+gd+rd,
  // an extra mem_start pulse in cycle spur. Records the cycle mdr_valid appears (-1 if never).
  task automatic xact(input logic we, input mem_size_t sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rw, input int gd, input int rd,
                      input int spur);
    mem_start = 1'b1; mem_we = we; mem_size = sz; mem_unsigned = uns; addr = a; wdata = wd;
    r_lat = -1; r_seen = 1'b0; r_unstable = 1'b0; r_mis = 1'b0; r_err = 1'b0;
    for (int c = 1; c <= 400 && r_lat < 0; c++) begin
      tick;
      mem_start = c == spur;
      bus_gnt = c == 1 + gd;
      bus_rvalid = c == 1 + gd + rd;
      bus_rdata = rw;
      if (bus_req) begin
        if (!r_seen) begin
          r_seen = 1'b1; r_addr = bus_addr; r_strb = bus_wstrb; r_wdata = bus_wdata; r_we = bus_we;
        end else if (bus_addr !== r_addr || bus_wstrb !== r_strb || bus_wdata !== r_wdata || bus_we !== r_we)
          r_unstable = 1'b1;
      end
      if (mdr_valid) begin
        r_lat = c; r_mis = mem_misalign; r_err = mem_err;
      end
    end
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
  endtask
  initial begin
    logic seen_v;
    tick; tick;
    chk("rst_mdr_valid", mdr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_wstrb", bus_wstrb, 0);
    rst_n = 1'b1;
    tick;
    xact(1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0, 32'h11223344, 0, 2, 4);
    tick;
    mem_start = 1'b0;
    chk("lw_lat", r_lat, 4);
    chk("lw_addr", r_addr, 32'h100);
    chk("lw_wstrb", r_strb, 0);
    chk("lw_we", r_we, 0);
    chk("lw_rdata", rdata, 32'h11223344);
    chk("lw_mis", r_mis, 0);
    chk("lw_err", r_err, 0);
    chk("lw_done_start_ignored", busy, 0);
    xact(1'b0, MEM_BYTE, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, -1);
    chk("lb_lat", r_lat, 2);
    chk("lb_addr", r_addr, 32'h100);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    tick;
    xact(1'b0, MEM_BYTE, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, -1);
    chk("lbu_rdata", rdata, 32'h00000080);
    tick;
    xact(1'b1, MEM_HALF, 1'b0, 32'h202, 32'hABCD, 32'h0, 0, 1, -1);
    chk("sh_lat", r_lat, 3);
    chk("sh_addr", r_addr, 32'h200);
    chk("sh_wstrb", r_strb, 4'b1100);
    chk("sh_wdata", r_wdata, 32'hABCDABCD);
    chk("sh_we", r_we, 1);
    chk("sh_rdata_kept", rdata, 32'h00000080);
    tick;
    xact(1'b1, MEM_BYTE, 1'b0, 32'h001, 32'h5A, 32'h0, 1, 0, -1);
    chk("sb_wstrb", r_strb, 4'b0010);
    chk("sb_wdata", r_wdata, 32'h5A5A5A5A);
    tick;
    xact(1'b0, MEM_WORD, 1'b0, 32'h101, 32'h0, 32'h12345678, 1000, 0, -1);
    chk("mis_no_req", r_seen, 0);
    chk("mis_lat", r_lat, 2);
    chk("mis_flag", r_mis, 1);
    chk("mis_rdata_kept", rdata, 32'h00000080);
    tick;
    xact(1'b0, MEM_HALF, 1'b0, 32'h102, 32'h0, 32'h8001FFFF, 5, 0, 3);
    tick;
    chk("gw_lat", r_lat, 7);
    chk("gw_stable", r_unstable, 0);
    chk("gw_addr", r_addr, 32'h100);
    chk("gw_rdata", rdata, 32'hFFFF8001);
    chk("gw_start_ignored", busy, 0);
    mem_start = 1'b1; mem_we = 1'b0; mem_size = MEM_WORD; addr = 32'h300;
    tick;
    mem_start = 1'b0; bus_gnt = 1'b1;
    tick;
    bus_gnt = 1'b0;
    chk("rr_busy_resp", busy, 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rr_busy", busy, 0);
    chk("rr_bus_req", bus_req, 0);
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    tick;
    bus_rvalid = 1'b0;
    seen_v = mdr_valid;
    for (int i = 0; i < 3; i++) begin
      tick;
      seen_v |= mdr_valid;
    end
    chk("rr_late_rvalid", seen_v, 0);
    chk("rr_rdata", rdata, 0);
    xact(1'b0, MEM_WORD, 1'b0, 32'h400, 32'h0, 32'h0, 0, 1000, -1);
`ifdef MEM_TIMEOUT_EN
    chk("to_lat", r_lat, 257);
    chk("to_err", r_err, 1);
    chk("to_rdata", rdata, MEM_ERR_DATA);
`else
    chk("wait_no_done", r_lat, -1);
    chk("wait_busy", busy, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
